// File: rtl/alu4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu4_cmd_sequencer
// Brief    : Command sequencer with 4x4 register file in front of a 4-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu4_cmd_sequencer #(
    parameter int ALU_WAIT = 0,
    parameter int RPT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_kind,
    input  logic [3:0]       cmd_op,
    input  logic [1:0]       cmd_dst,
    input  logic [1:0]       cmd_srca,
    input  logic [1:0]       cmd_srcb,
    input  logic [3:0]       cmd_imm,
    input  logic [RPT_W-1:0] cmd_rpt,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [3:0]       alu_out,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic [1:0]       rd_sel,
    output logic [3:0]       rd_data,
    output logic             res_valid,
    output logic [3:0]       res_data,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_exec   = 1'b1;
    localparam logic [1:0] c_wait_last = 2'(ALU_WAIT);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [3:0]       r_regs [4];
    logic [3:0]       r_opa;
    logic [3:0]       r_opb;
    logic [3:0]       r_op;
    logic [1:0]       r_dst;
    logic [RPT_W-1:0] r_iter;
    logic [1:0]       r_wait;
    logic             r_res_valid;
    logic [3:0]       r_res_data;
    logic             r_flag_z;
    logic             r_flag_c;

    logic             w_accept;
    logic             w_exec;
    logic             w_eval_done;
    logic             w_last;

    assign cmd_ready   = (r_state == c_st_idle);
    assign busy        = ~cmd_ready;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_exec      = (r_state == c_st_exec);
    assign w_eval_done = w_exec && (r_wait == c_wait_last);
    assign w_last      = w_eval_done && (r_iter == '0);

    // ALU lines are gated by the state register only, so they stay stable
    // across the whole evaluation window and read zero while idle.
    assign alu_a     = w_exec ? r_opa : 4'd0;
    assign alu_b     = w_exec ? r_opb : 4'd0;
    assign alu_op    = w_exec ? r_op  : 4'd0;

    assign rd_data   = r_regs[rd_sel];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept && !cmd_kind) w_state_nxt = c_st_exec;
            c_st_exec: if (w_last)                w_state_nxt = c_st_idle;
            default:                              w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 4'd0;
            end
            r_opa       <= 4'd0;
            r_opb       <= 4'd0;
            r_op        <= 4'd0;
            r_dst       <= 2'd0;
            r_iter      <= '0;
            r_wait      <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'd0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_accept) begin
                if (cmd_kind) begin
                    r_regs[cmd_dst] <= cmd_imm;
                    r_res_data      <= cmd_imm;
                    r_res_valid     <= 1'b1;
                end else begin
                    // Operand snapshot decouples the evaluation from write-back
                    // when dst aliases a source register.
                    r_opa  <= r_regs[cmd_srca];
                    r_opb  <= r_regs[cmd_srcb];
                    r_op   <= cmd_op;
                    r_dst  <= cmd_dst;
                    r_iter <= cmd_rpt;
                    r_wait <= 2'd0;
                end
            end
            if (w_exec) begin
                if (!w_eval_done) begin
                    r_wait <= r_wait + 2'd1;
                end else begin
                    r_wait        <= 2'd0;
                    r_regs[r_dst] <= alu_out;
                    r_flag_z      <= alu_z;
                    r_flag_c      <= alu_c;
                    if (r_iter != '0) begin
                        r_iter <= r_iter - RPT_W'(1);
                        r_opa  <= alu_out;
                    end else begin
                        r_res_data  <= alu_out;
                        r_res_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4_cmd_sequencer
// Brief    : Directed + random bench for alu4_cmd_sequencer (ALU_WAIT 0 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu4_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic       cmd_kind  [2];
    logic [3:0] cmd_op    [2];
    logic [1:0] cmd_dst   [2];
    logic [1:0] cmd_srca  [2];
    logic [1:0] cmd_srcb  [2];
    logic [3:0] cmd_imm   [2];
    logic [1:0] cmd_rpt   [2];
    logic [3:0] alu_a     [2];
    logic [3:0] alu_b     [2];
    logic [3:0] alu_op    [2];
    logic [3:0] alu_out   [2];
    logic       alu_z     [2];
    logic       alu_c     [2];
    logic [1:0] rd_sel    [2];
    logic [3:0] rd_data   [2];
    logic       res_valid [2];
    logic [3:0] res_data  [2];
    logic       flag_z    [2];
    logic       flag_c    [2];
    logic       busy      [2];

    int         n_checks = 0;
    int         n_errors = 0;
    int         rv_cnt [2] = '{0, 0};

    logic [3:0]  m_regs [2][4];
    logic        m_z [2];
    logic        m_c [2];
    int          e_lat;
    logic [3:0]  e_res;
    logic [11:0] e_trace [$];
    logic [11:0] trace [$];

    always #5 clk = ~clk;

    // Bench-side ALU: shift / arithmetic / logic / compare groups, {carry,result}.
    function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            4'h0: alu_f = {a[3], a[2:0], 1'b0};
            4'h1: alu_f = {a[0], 1'b0, a[3:1]};
            4'h2: alu_f = {a[3], a[2:0], a[3]};
            4'h3: alu_f = {a[0], a[0], a[3:1]};
            4'h4: alu_f = {1'b0, a} + {1'b0, b};
            4'h5: alu_f = {1'b0, a} - {1'b0, b};
            4'h6: alu_f = {1'b0, a} + 5'd1;
            4'h7: alu_f = {1'b0, a} - 5'd1;
            4'h8: alu_f = {1'b0, a & b};
            4'h9: alu_f = {1'b0, a | b};
            4'hA: alu_f = {1'b0, a ^ b};
            4'hB: alu_f = {1'b0, ~(a & b)};
            4'hC: alu_f = {1'b0, 3'd0, a == b};
            4'hD: alu_f = {a < b, 3'd0, a < b};
            4'hE: alu_f = {a > b, 3'd0, a > b};
            default: alu_f = {1'b0, a};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu4_cmd_sequencer #(.ALU_WAIT(g * 2), .RPT_W(2)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_kind  (cmd_kind[g]),
            .cmd_op    (cmd_op[g]),
            .cmd_dst   (cmd_dst[g]),
            .cmd_srca  (cmd_srca[g]),
            .cmd_srcb  (cmd_srcb[g]),
            .cmd_imm   (cmd_imm[g]),
            .cmd_rpt   (cmd_rpt[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_op    (alu_op[g]),
            .alu_out   (alu_out[g]),
            .alu_z     (alu_z[g]),
            .alu_c     (alu_c[g]),
            .rd_sel    (rd_sel[g]),
            .rd_data   (rd_data[g]),
            .res_valid (res_valid[g]),
            .res_data  (res_data[g]),
            .flag_z    (flag_z[g]),
            .flag_c    (flag_c[g]),
            .busy      (busy[g])
        );
        assign {alu_c[g], alu_out[g]} = alu_f(alu_op[g], alu_a[g], alu_b[g]);
        assign alu_z[g] = (alu_out[g] == 4'd0);
    end

    always @(negedge clk) begin
        if (res_valid[0] === 1'b1) rv_cnt[0]++;
        if (res_valid[1] === 1'b1) rv_cnt[1]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) m_regs[d][r] = 4'd0;
            m_z[d] = 1'b0;
            m_c[d] = 1'b0;
        end
    endtask

    // Reference: evaluate the command as a whole from the register-file view.
    task automatic model_cmd(input int d, input logic kind, input logic [3:0] op,
                             input logic [1:0] dst, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [3:0] imm,
                             input logic [1:0] rpt);
        logic [3:0] v;
        logic [3:0] b;
        logic [4:0] r;
        int         wcyc;
        e_trace.delete();
        wcyc = (d == 0) ? 1 : 3;
        if (kind) begin
            e_res          = imm;
            e_lat          = 0;
            m_regs[d][dst] = imm;
        end else begin
            v = m_regs[d][sa];
            b = m_regs[d][sb];
            for (int it = 0; it <= int'(rpt); it++) begin
                for (int k = 0; k < wcyc; k++) e_trace.push_back({op, b, v});
                r      = alu_f(op, v, b);
                v      = r[3:0];
                m_c[d] = r[4];
                m_z[d] = (v == 4'd0);
            end
            m_regs[d][dst] = v;
            e_res          = v;
            e_lat          = (int'(rpt) + 1) * wcyc;
        end
    endtask

    task automatic drive(input int d, input logic kind, input logic [3:0] op,
                         input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [3:0] imm,
                         input logic [1:0] rpt);
        cmd_kind[d] = kind;
        cmd_op[d]   = op;
        cmd_dst[d]  = dst;
        cmd_srca[d] = sa;
        cmd_srcb[d] = sb;
        cmd_imm[d]  = imm;
        cmd_rpt[d]  = rpt;
    endtask

    task automatic check_regs(input int d, input string tag);
        for (int r = 0; r < 4; r++) begin
            rd_sel[d] = r[1:0];
            #1;
            check($sformatf("%s d%0d rd r%0d", tag, d, r), rd_data[d], m_regs[d][r]);
        end
    endtask

    // Called one step after the accept edge; returns in the res_valid cycle.
    task automatic wait_result(input int d, input string tag);
        int lat;
        int bad;
        trace.delete();
        lat = 0;
        while (res_valid[d] !== 1'b1 && lat < 100) begin
            trace.push_back({alu_op[d], alu_b[d], alu_a[d]});
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s d%0d latency", tag, d), lat, e_lat);
        check($sformatf("%s d%0d res_data", tag, d), res_data[d], e_res);
        check($sformatf("%s d%0d flag_z", tag, d), flag_z[d], m_z[d]);
        check($sformatf("%s d%0d flag_c", tag, d), flag_c[d], m_c[d]);
        check($sformatf("%s d%0d ready", tag, d), cmd_ready[d], 1);
        check($sformatf("%s d%0d alu idle", tag, d), {alu_op[d], alu_b[d], alu_a[d]}, 0);
        bad = (trace.size() != e_trace.size()) ? 1 : 0;
        if (bad == 0) begin
            foreach (trace[i]) if (trace[i] !== e_trace[i]) bad++;
        end
        check($sformatf("%s d%0d alu trace errs", tag, d), bad, 0);
        check_regs(d, tag);
    endtask

    task automatic run_cmd(input int d, input logic kind, input logic [3:0] op,
                           input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [3:0] imm,
                           input logic [1:0] rpt, input string tag);
        int n;
        model_cmd(d, kind, op, dst, sa, sb, imm, rpt);
        drive(d, kind, op, dst, sa, sb, imm, rpt);
        cmd_valid[d] = 1'b1;
        n = 0;
        while (cmd_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("%s d%0d ready at offer", tag, d), cmd_ready[d], 1);
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
        wait_result(d, tag);
        @(posedge clk);
        #1;
        check($sformatf("%s d%0d pulse end", tag, d), res_valid[d], 0);
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("%s d%0d res_valid", tag, d), res_valid[d], 0);
        check($sformatf("%s d%0d res_data", tag, d), res_data[d], 0);
        check($sformatf("%s d%0d flags", tag, d), {flag_z[d], flag_c[d]}, 0);
        check($sformatf("%s d%0d alu lines", tag, d), {alu_op[d], alu_b[d], alu_a[d]}, 0);
        check_regs(d, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        int rv1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            rd_sel[d]    = 2'd0;
            drive(d, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0);
        end
        model_reset();

        // Power-on reset, then a reset while idle after loading registers
        repeat (3) @(negedge clk);
        check_zero(0, "por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("por d%0d ready", d), cmd_ready[d], 1);
            check_regs(d, "por");
            run_cmd(d, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'd9, 2'd0, "pre-rst ld");
            run_cmd(d, 1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 4'd6, 2'd0, "pre-rst ld");
        end
        run_cmd(0, 1'b0, 4'h4, 2'd2, 2'd1, 2'd3, 4'd0, 2'd0, "pre-rst add");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) check_zero(d, "idle rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("idle rst d%0d ready", d), cmd_ready[d], 1);
            check($sformatf("idle rst d%0d busy", d), busy[d], 0);
        end

        // Back-to-back loads then ADD 5+3
        model_cmd(0, 1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'd5, 2'd0);
        drive(0, 1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'd5, 2'd0);
        cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        check("b2b ld0 valid", res_valid[0], 1);
        check("b2b ld0 data", res_data[0], 5);
        model_cmd(0, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'd3, 2'd0);
        drive(0, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'd3, 2'd0);
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        check("b2b ld1 valid", res_valid[0], 1);
        check("b2b ld1 data", res_data[0], 3);
        @(posedge clk);
        #1;
        check("b2b pulse end", res_valid[0], 0);
        run_cmd(0, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd0, "add53");
        check("add53 res", res_data[0], 8);
        check("add53 flags", {flag_z[0], flag_c[0]}, 0);

        // Accumulate 1+1+1+1+1
        run_cmd(0, 1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'd1, 2'd0, "acc ld");
        run_cmd(0, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'd1, 2'd0, "acc ld");
        run_cmd(0, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd3, "acc");
        check("acc res", res_data[0], 5);

        // Wrap: F+1 -> 0 with Z and C, then a load leaves flags alone
        run_cmd(0, 1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'hF, 2'd0, "wrap ld");
        run_cmd(0, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'h1, 2'd0, "wrap ld");
        run_cmd(0, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd0, "wrap");
        check("wrap res", res_data[0], 0);
        check("wrap flags", {flag_z[0], flag_c[0]}, 2'b11);
        run_cmd(0, 1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 4'h7, 2'd0, "wrap ld after");
        check("wrap flags kept", {flag_z[0], flag_c[0]}, 2'b11);

        // Backpressure at ALU_WAIT=2: second command held during a rpt=2 op
        run_cmd(1, 1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 4'd2, 2'd0, "bp ld");
        run_cmd(1, 1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 4'd3, 2'd0, "bp ld");
        rv1 = rv_cnt[1];
        model_cmd(1, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd2);
        drive(1, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd2);
        cmd_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 1'b0, 4'h4, 2'd2, 2'd2, 2'd1, 4'd0, 2'd0);
        wait_result(1, "bp first");
        check("bp first res", res_data[1], 11);
        model_cmd(1, 1'b0, 4'h4, 2'd2, 2'd2, 2'd1, 4'd0, 2'd0);
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        wait_result(1, "bp second");
        check("bp second res", res_data[1], 14);
        repeat (8) @(posedge clk);
        #1;
        check("bp pulse count", rv_cnt[1] - rv1, 2);
        check_regs(1, "bp after");

        // Reset in the middle of a rpt=3 ADD
        drive(1, 1'b0, 4'h4, 2'd2, 2'd0, 2'd1, 4'd0, 2'd3);
        cmd_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        rv0 = rv_cnt[0];
        rv1 = rv_cnt[1];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midop busy before rst", busy[1], 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero(1, "midop rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midop ready after release", cmd_ready[1], 1);
        repeat (15) @(posedge clk);
        #1;
        check("midop no res_valid d1", rv_cnt[1] - rv1, 0);
        check("midop no res_valid d0", rv_cnt[0] - rv0, 0);
        check_regs(0, "midop");
        check_regs(1, "midop");

        // Random commands against the reference model
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 2; d++) begin
                run_cmd(d, ($urandom_range(0, 2) == 0),
                        4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                        $sformatf("rnd%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu4_cmd_sequencer.md
Name: alu4_cmd_sequencer

Overview:
Command-driven sequencer for the team's 4-bit combinational ALU (opcode map: 0000-0011 shift, 0100-0111 arithmetic, 1000-1011 logic, 1100-1111 compare). It owns a 4-entry x 4-bit register file, accepts commands over a valid/ready handshake, and drives the ALU operand and opcode lines. It captures the ALU result and Z/C flags, and can repeat an operation to accumulate. It sits between the top-level I/O and the ALU instance and gives the ALU state it does not have itself.

Parameters:
ALU_WAIT, 0, extra settle cycles per ALU evaluation before capture (legal 0..3)
RPT_W, 2, width of the repeat field (max extra iterations = 2^RPT_W-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept; high only in IDLE
cmd_kind  in  1  0 = ALU op, 1 = load immediate
cmd_op  in  4  ALU opcode
cmd_dst  in  2  destination register
cmd_srca  in  2  operand A register
cmd_srcb  in  2  operand B register
cmd_imm  in  4  immediate for load
cmd_rpt  in  RPT_W  extra iterations (0 = single evaluation)
alu_a  out  4  ALU operand A
alu_b  out  4  ALU operand B
alu_op  out  4  ALU opcode
alu_out  in  4  ALU result
alu_z  in  1  ALU zero flag
alu_c  in  1  ALU carry flag
rd_sel  in  2  debug read select
rd_data  out  4  regfile[rd_sel], combinational, pre-edge value
res_valid  out  1  one-cycle pulse: command complete
res_data  out  4  result of the last completed command, held until the next completion
flag_z  out  1  registered Z of the last ALU op
flag_c  out  1  registered C of the last ALU op
busy  out  1  equals !cmd_ready

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE; regfile all 0; res_valid 0; res_data 0; flag_z 0; flag_c 0.
  - alu_a, alu_b and alu_op are 0; iteration and wait counters are 0.
  - A reset mid-operation aborts the command. No res_valid is produced.
- Handshake: a transfer happens on a rising edge where cmd_valid && cmd_ready.
  - Command fields are sampled only at that edge.
  - cmd_valid while busy is ignored and not queued; the source must hold it.
- Load immediate (cmd_kind=1), accepted at edge E:
  - regfile[cmd_dst] <= cmd_imm at E.
  - res_data <= cmd_imm and res_valid = 1 in the cycle after E.
  - flag_z and flag_c are unchanged. State stays IDLE, so back-to-back loads run at one per cycle.
- ALU op (cmd_kind=0), accepted at edge E:
  - At E, the opA/opB snapshot registers take regfile[srca] and regfile[srcb].
  - Opcode, dst and iter_cnt <= cmd_rpt are latched; state -> EXEC.
- EXEC:
  - alu_a=opA, alu_b=opB, alu_op=latched op; all are registered, so stable for the whole state.
  - The state lasts 1+ALU_WAIT cycles, counted by wait_cnt.
  - On the last EXEC edge: regfile[dst] <= alu_out; flag_z <= alu_z; flag_c <= alu_c.
  - If iter_cnt != 0 on that edge: iter_cnt decrements, opA <= alu_out, opB is unchanged, and EXEC restarts.
  - If iter_cnt == 0 on that edge: res_data <= alu_out, res_valid is pulsed in the next cycle, and state -> IDLE.
- Latency: res_valid is high in the cycle after edge E + (cmd_rpt+1)*(1+ALU_WAIT).
  - cmd_ready is high again in that same cycle, so a new command may be accepted while res_valid is high.
- Outside EXEC, alu_a, alu_b and alu_op are driven to 0.
- Hazards:
  - A command accepted right after a completion sees the written-back value, because write-back precedes acceptance by at least one edge.
  - srca, srcb and dst may alias. The snapshot keeps operands stable even when dst == srca.
- Arithmetic is 4-bit modulo throughout; the sequencer never widens or sign-extends. Flags come from the ALU only.
- Repeat wrap: the iteration counter never underflows. Maximum cmd_rpt=3 gives 4 evaluations.

Test Plan:
1. Reset: assert rst_n=0 mid-idle -> all outputs 0; after release cmd_ready=1 and rd_data=0 for every rd_sel.
2. LOADI r0=5, LOADI r1=3 on back-to-back cycles, then ADD (op 0100, dst r2, a r0, b r1, rpt 0), ALU_WAIT=0:
   - each load pulses res_valid for one cycle;
   - the ADD gives res_data=8, flag_z=0, flag_c=0, one cycle after accept;
   - rd_sel=2 then reads 8.
3. Accumulate: r0=1, r1=1, ADD dst r2 rpt 3 -> alu_a steps 1,2,3,4; res_data=5; res_valid 4 cycles after accept; r2=5.
4. Wrap and flags: r0=F, r1=1, ADD -> res_data=0, flag_z=1, flag_c=1. A following LOADI leaves both flags at 1.
5. Backpressure: hold cmd_valid with a second command during a rpt=2 op at ALU_WAIT=2 -> the second command is accepted exactly in the res_valid cycle (9 cycles after the first accept), is not lost, and is not executed twice.
6. Reset mid-op: during EXEC of a rpt=3 ADD, pulse rst_n low -> regs 0, no res_valid, cmd_ready=1 next cycle after release.
